// File: rtl/dac_spi_multi.sv
// SPI engine for NUM_DACS AD5662-class DACs: shared SYNC/SCLK, one DIN lane per DAC.
// One frame per start pulse: IDLE -> SHIFT -> GAP -> IDLE, all pins registered.

module dac_spi_lane #(
    parameter int DATA_WIDTH = 16,
    parameter int CTRL_BITS  = 8
) (
    input  logic                  dataclk,
    input  logic                  reset,
    input  logic                  i_load,
    input  logic                  i_shift,
    input  logic                  i_clear,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_en,
    output logic                  o_din
);
    localparam int FRAME_BITS = CTRL_BITS + DATA_WIDTH;

    logic [FRAME_BITS-1:0] w_word;
    logic [FRAME_BITS-1:0] r_shift;
    logic                  r_din;

    // PD1 = ~en selects 100 kOhm to GND on disabled lanes; PD0 and upper pad bits stay 0
    always_comb begin
        w_word                   = '0;
        w_word[DATA_WIDTH-1:0]   = i_data;
        w_word[DATA_WIDTH+1]     = ~i_en;
    end

    always_ff @(posedge dataclk) begin
        if (reset) begin
            r_shift <= '0;
            r_din   <= 1'b0;
        end else if (i_load) begin
            r_din   <= w_word[FRAME_BITS-1];
            r_shift <= {w_word[FRAME_BITS-2:0], 1'b0};
        end else if (i_shift) begin
            r_din   <= r_shift[FRAME_BITS-1];
            r_shift <= {r_shift[FRAME_BITS-2:0], 1'b0};
        end else if (i_clear) begin
            r_din   <= 1'b0;
        end
    end

    assign o_din = r_din;
endmodule

module dac_spi_multi #(
    parameter int NUM_DACS   = 8,
    parameter int DATA_WIDTH = 16,
    parameter int CTRL_BITS  = 8,
    parameter int CLK_DIV    = 1,
    parameter int SYNC_IDLE  = 2
) (
    input  logic                           dataclk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [NUM_DACS*DATA_WIDTH-1:0] dac_data,
    input  logic [NUM_DACS-1:0]            dac_en,
    output logic                           busy,
    output logic                           done,
    output logic                           overrun,
    output logic                           DAC_SYNC,
    output logic                           DAC_SCLK,
    output logic [NUM_DACS-1:0]            DAC_DIN
);
    localparam int FRAME_BITS = CTRL_BITS + DATA_WIDTH;
    localparam int BIT_W      = $clog2(FRAME_BITS);
    localparam int PH_W       = $clog2(CLK_DIV + 1);
    localparam int GAP_W      = $clog2(SYNC_IDLE + 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

    state_t             r_state, w_state_nxt;
    logic [BIT_W-1:0]   r_bit_cnt, w_bit_nxt;
    logic [PH_W-1:0]    r_ph_cnt, w_ph_nxt;
    logic [GAP_W-1:0]   r_gap_cnt, w_gap_nxt;
    logic               r_sync, w_sync_nxt;
    logic               r_sclk, w_sclk_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_done, w_done_nxt;
    logic               r_overrun;
    logic               w_load, w_shift, w_clear;
    logic               w_ph_end, w_bit_end, w_last;
    logic [NUM_DACS-1:0] w_din;

    assign w_ph_end  = (r_ph_cnt == '0);
    assign w_bit_end = w_ph_end && !r_sclk;
    assign w_last    = (r_bit_cnt == '0);

    always_ff @(posedge dataclk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= '0;
            r_ph_cnt  <= '0;
            r_gap_cnt <= '0;
            r_sync    <= 1'b1;
            r_sclk    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_nxt;
            r_ph_cnt  <= w_ph_nxt;
            r_gap_cnt <= w_gap_nxt;
            r_sync    <= w_sync_nxt;
            r_sclk    <= w_sclk_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_overrun <= r_overrun | (start & r_busy);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_SHIFT;
            S_SHIFT: if (w_bit_end && w_last) w_state_nxt = S_GAP;
            S_GAP:   if (r_gap_cnt == '0) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Each bit: CLK_DIV cycles SCLK high, then CLK_DIV low; DIN advances only on the rise
    always_comb begin
        w_sync_nxt = 1'b1;
        w_sclk_nxt = 1'b0;
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
        w_bit_nxt  = r_bit_cnt;
        w_ph_nxt   = r_ph_cnt;
        w_gap_nxt  = r_gap_cnt;
        w_load     = 1'b0;
        w_shift    = 1'b0;
        w_clear    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_load     = 1'b1;
                    w_sync_nxt = 1'b0;
                    w_sclk_nxt = 1'b1;
                    w_busy_nxt = 1'b1;
                    w_bit_nxt  = BIT_W'(FRAME_BITS - 1);
                    w_ph_nxt   = PH_W'(CLK_DIV - 1);
                end
            end
            S_SHIFT: begin
                w_sync_nxt = 1'b0;
                w_sclk_nxt = r_sclk;
                w_busy_nxt = 1'b1;
                if (!w_ph_end) begin
                    w_ph_nxt = r_ph_cnt - 1'b1;
                end else if (r_sclk) begin
                    w_sclk_nxt = 1'b0;
                    w_ph_nxt   = PH_W'(CLK_DIV - 1);
                end else if (w_last) begin
                    w_sync_nxt = 1'b1;
                    w_sclk_nxt = 1'b0;
                    w_done_nxt = 1'b1;
                    w_clear    = 1'b1;
                    w_gap_nxt  = GAP_W'(SYNC_IDLE - 1);
                end else begin
                    w_sclk_nxt = 1'b1;
                    w_shift    = 1'b1;
                    w_bit_nxt  = r_bit_cnt - 1'b1;
                    w_ph_nxt   = PH_W'(CLK_DIV - 1);
                end
            end
            S_GAP: begin
                if (r_gap_cnt != '0) begin
                    w_busy_nxt = 1'b1;
                    w_gap_nxt  = r_gap_cnt - 1'b1;
                end
            end
            default: ;
        endcase
    end

    for (genvar g = 0; g < NUM_DACS; g++) begin : g_lane
        dac_spi_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .CTRL_BITS  (CTRL_BITS)
        ) u_lane (
            .dataclk (dataclk),
            .reset   (reset),
            .i_load  (w_load),
            .i_shift (w_shift),
            .i_clear (w_clear),
            .i_data  (dac_data[g*DATA_WIDTH +: DATA_WIDTH]),
            .i_en    (dac_en[g]),
            .o_din   (w_din[g])
        );
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign overrun  = r_overrun;
    assign DAC_SYNC = r_sync;
    assign DAC_SCLK = r_sclk;
    assign DAC_DIN  = w_din;
endmodule
